// File: rtl/lab7_pkg.sv
// Shared constants for the lab 7 switch-conditioning path.
package lab7_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

  // Bit positions of the expression inputs within the 4-bit switch bus
  localparam int SW_A = 3;
  localparam int SW_B = 2;
  localparam int SW_C = 1;
  localparam int SW_D = 0;

endpackage

// File: rtl/switch_debounce4_bit.sv
// Single-bit conditioner: two-flop synchroniser, debounce counter, stable level
// and registered rise/fall pulses.
module debounce_bit
  import lab7_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Derived from registered state only, so the top can align its changed flop
  // with the rise/fall flops without any path from raw.
  assign accept = (s2 != stable) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= accept && s2;
      fall <= accept && !s2;
      if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else if (s2 != stable) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_debounce4.sv
// Four independent debounced switch inputs with edge pulses and a combined
// change strobe.
module switch_debounce4
  import lab7_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_raw,
  output logic [3:0] sw_stable,
  output logic [3:0] sw_rise,
  output logic [3:0] sw_fall,
  output logic       changed
);

  logic [3:0] accept;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i]),
      .accept (accept[i])
    );
  end

  // Same edge as the per-bit pulse flops, so changed == |(sw_rise | sw_fall)
  always_ff @(posedge clk) begin
    if (rst) changed <= 1'b0;
    else     changed <= |accept;
  end

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed bench for switch_debounce4 with a per-cycle expectation queue.
module tb_switch_debounce4;
  import lab7_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_raw;
  logic [3:0] sw_stable;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       changed;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];

  switch_debounce4 #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, queue what must be seen after the edge, compare.
  task automatic cyc(input logic [3:0] raw, input logic r, input logic [3:0] e_stable,
                     input logic [3:0] e_rise, input logic [3:0] e_fall, input string tag);
    logic [12:0] obs;
    logic [12:0] exp_v;
    sw_raw = raw;
    rst    = r;
    exp_q.push_back({e_stable, e_rise, e_fall, |(e_rise | e_fall)});
    @(posedge clk);
    #1;
    obs = {sw_stable, sw_rise, sw_fall, changed};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed stable=%b rise=%b fall=%b changed=%b expected stable=%b rise=%b fall=%b changed=%b",
               tag, obs[12:9], obs[8:5], obs[4:1], obs[0],
               exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask

  task automatic idle(input int n, input logic [3:0] raw, input logic r,
                      input logic [3:0] e_stable, input string tag);
    for (int k = 0; k < n; k++) cyc(raw, r, e_stable, 4'b0000, 4'b0000, tag);
  endtask

  initial begin
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [3:0] m_c;
    logic [3:0] m_d;
    m_a = 4'(1 << SW_A);
    m_b = 4'(1 << SW_B);
    m_c = 4'(1 << SW_C);
    m_d = 4'(1 << SW_D);

    // Reset holds everything low despite all switches high
    idle(3, 4'b1111, 1'b1, 4'b0000, "reset_hold");
    idle(5, 4'b1111, 1'b0, 4'b0000, "post_reset_wait");
    cyc(4'b1111, 1'b0, 4'b1111, 4'b1111, 4'b0000, "post_reset_accept");
    idle(2, 4'b1111, 1'b0, 4'b1111, "post_reset_settle");

    // All bits fall together
    idle(5, 4'b0000, 1'b0, 4'b1111, "all_fall_wait");
    cyc(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, "all_fall_accept");
    idle(2, 4'b0000, 1'b0, 4'b0000, "all_fall_settle");

    // Clean rising edge on A
    idle(5, m_a, 1'b0, 4'b0000, "clean_a_wait");
    cyc(m_a, 1'b0, m_a, m_a, 4'b0000, "clean_a_accept");
    idle(2, m_a, 1'b0, m_a, "clean_a_settle");

    // Bounce on C: 1,0,1,0 then final 1 held
    cyc(m_a | m_c, 1'b0, m_a, 4'b0000, 4'b0000, "bounce_c_1");
    cyc(m_a,       1'b0, m_a, 4'b0000, 4'b0000, "bounce_c_0");
    cyc(m_a | m_c, 1'b0, m_a, 4'b0000, 4'b0000, "bounce_c_1");
    cyc(m_a,       1'b0, m_a, 4'b0000, 4'b0000, "bounce_c_0");
    idle(5, m_a | m_c, 1'b0, m_a, "bounce_c_final_wait");
    cyc(m_a | m_c, 1'b0, m_a | m_c, m_c, 4'b0000, "bounce_c_accept");
    idle(2, m_a | m_c, 1'b0, m_a | m_c, "bounce_c_settle");

    // Glitch on D one cycle short of acceptance
    idle(3, m_a | m_c | m_d, 1'b0, m_a | m_c, "glitch_d_high");
    idle(6, m_a | m_c,       1'b0, m_a | m_c, "glitch_d_low");

    // Simultaneous fall of A and C, rise, then fall again
    idle(5, 4'b0000, 1'b0, m_a | m_c, "simul_fall0_wait");
    cyc(4'b0000, 1'b0, 4'b0000, 4'b0000, m_a | m_c, "simul_fall0_accept");
    idle(2, 4'b0000, 1'b0, 4'b0000, "simul_fall0_settle");
    idle(5, m_a | m_c, 1'b0, 4'b0000, "simul_rise_wait");
    cyc(m_a | m_c, 1'b0, m_a | m_c, m_a | m_c, 4'b0000, "simul_rise_accept");
    idle(2, m_a | m_c, 1'b0, m_a | m_c, "simul_rise_settle");
    idle(5, 4'b0000, 1'b0, m_a | m_c, "simul_fall_wait");
    cyc(4'b0000, 1'b0, 4'b0000, 4'b0000, m_a | m_c, "simul_fall_accept");
    idle(2, 4'b0000, 1'b0, 4'b0000, "simul_fall_settle");

    // Reset mid-count on B discards the partial count
    idle(3, m_b, 1'b0, 4'b0000, "midrst_count");
    cyc(m_b, 1'b1, 4'b0000, 4'b0000, 4'b0000, "midrst_reset");
    idle(5, m_b, 1'b0, 4'b0000, "midrst_recount");
    cyc(m_b, 1'b0, m_b, m_b, 4'b0000, "midrst_accept");
    idle(2, m_b, 1'b0, m_b, "midrst_settle");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce4.md
Name: switch_debounce4

Overview:
- Input-conditioning stage directly upstream of the lab's combinational Boolean-expression blocks.
- Takes four raw, asynchronous slide-switch/button levels and synchronises each bit to clk.
- Debounces each bit independently and drives clean, glitch-free A..D levels into the expression logic.
- Also produces single-cycle edge pulses for LED/demo logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised input must differ from the stable value before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-bit counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  4  raw switch levels, asynchronous to clk; bit 3 = A, 2 = B, 1 = C, 0 = D.
- sw_stable  output  4  debounced levels, same bit mapping; feeds expression inputs.
- sw_rise  output  4  one-cycle pulse per bit when sw_stable bit goes 0→1.
- sw_fall  output  4  one-cycle pulse per bit when sw_stable bit goes 1→0.
- changed  output  1  high for exactly the cycle in which any sw_rise or sw_fall bit is high; equals OR of sw_rise and sw_fall.

Behaviour:
- Reset (rst=1 at an edge): the following all go to 0 and hold while rst=1.
  - Synchroniser flops s1, s2.
  - All counters.
  - sw_stable, sw_rise, sw_fall, changed.
  - Reset overrides any debounce in progress; there is no partial-count carry-over.
- Synchroniser, per bit, every edge: s1 <= sw_raw, then s2 <= s1. This is a two-flop chain and the only logic that touches sw_raw.
- Debounce, per bit i, evaluated every edge:
  - s2[i] == sw_stable[i]: cnt[i] <= 0; no pulse.
  - s2[i] != sw_stable[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1; no pulse.
  - s2[i] != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= s2[i]; cnt[i] <= 0; sw_rise[i] or sw_fall[i] (per new value) <= 1 for this one cycle.
  - sw_rise, sw_fall and changed are registered. They are 0 in every cycle with no acceptance.
- Latency:
  - sw_raw changes before edge 0 and stays constant. sw_stable updates at edge DEBOUNCE_CYCLES+1.
  - The pulse is high during the cycle following that edge.
  - Example: DEBOUNCE_CYCLES=4 gives an update at edge 5.
- Bounce rejection: any return of s2[i] to sw_stable[i] before acceptance clears cnt[i]. The full count restarts on the next difference.
- Bits are fully independent. Simultaneous acceptances on several bits assert the corresponding rise/fall bits in the same cycle, with changed=1 once.
- Counter never wraps; its maximum value is DEBOUNCE_CYCLES-1.
- No combinational path from sw_raw to any output.

Decomposition:
- Shared package/header lab7_pkg:
  - DEBOUNCE_CYCLES_DEFAULT = 500000.
  - SIM_DEBOUNCE_CYCLES = 4.
  - Bit-index constants SW_A=3, SW_B=2, SW_C=1, SW_D=0.
- One natural sub-module, debounce_bit:
  - Contains the two-flop synchroniser, counter, stable flop and rise/fall flops for a single bit.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated four times by generate.
  - switch_debounce4 adds only the OR-reduction flop for changed.

Test Plan:
1. Reset: sw_raw=4'b1111 held, rst=1 for 3 edges → sw_stable=0, sw_rise=sw_fall=0, changed=0 throughout. Release rst; with DEBOUNCE_CYCLES=4, sw_stable=4'b1111 after edge 5 post-release. sw_rise=4'b1111 and changed=1 for exactly one cycle.
2. Clean edge, DEBOUNCE_CYCLES=4: sw_raw[3] 0→1 before edge 0 → sw_stable[3]=1 after edge 5, not before. sw_rise[3]=1 for one cycle; other bits unchanged.
3. Bounce: sw_raw[1] toggles 1,0,1,0,1 on successive edges, then holds 1 → no change during the toggling. sw_stable[1] rises only DEBOUNCE_CYCLES+1 edges after the final 0→1.
4. Short glitch: sw_raw[0] high for 3 edges, then low → sw_stable[0] stays 0; sw_rise/sw_fall/changed stay 0.
5. Simultaneous: sw_raw 4'b0000→4'b1010 in one step → sw_stable=4'b1010 at edge 5. sw_rise=4'b1010 and changed=1 in the same single cycle. Then 4'b1010→4'b0000 gives sw_fall=4'b1010.
6. Reset mid-count: start a 0→1 on bit 2, assert rst at edge 3 for one edge, hold sw_raw → sw_stable[2] stays 0 through reset. It rises a full DEBOUNCE_CYCLES+2 edges after rst deasserts, with no early acceptance.
